merge: RTL and testbench
========================

# merge

Bus merge: connects N_MASTERS native-bus masters to a single slave port, the counterpart of the address-decoding split. A registered round-robin arbiter grants one master at a time and holds the grant until the slave returns ready. It sits in front of shared slaves (memory, peripheral bus) that several cores or DMA engines must reach.

## Interface
- TYPE, `D: bus type; `D request carries {valid, addr, wdata[31:0], wstrb[3:0]}; `I request carries {valid, addr}.
- N_MASTERS, 2: number of master ports, ≥1.
- ADDR_W, 32: address width.
- Derived: REQ_W = `BUS_REQ_W(TYPE, ADDR_W), with valid at bit REQ_W-1; RESP_W = `BUS_RESP_W = 33, as {rdata[31:0], ready}, ready at bit 0.
- Derived: SEL_W = max(1, clog2(N_MASTERS)).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, synchronous and active-low: sampled 0 on a rising edge resets the block.
- m_req  input  N_MASTERS*REQ_W  master requests; master i occupies slice [i*REQ_W +: REQ_W].
- m_resp  output  N_MASTERS*RESP_W  master responses; master i occupies slice [i*RESP_W +: RESP_W].
- s_req  output  REQ_W  request to the slave.
- s_resp  input  RESP_W  slave response.
- s_sel  output  SEL_W  index of the granted master; valid while BUSY, 0 otherwise.

## Operation
- Registered state: state {IDLE, BUSY}, sel[SEL_W-1:0], ptr[SEL_W-1:0] (round-robin start).
- IDLE:
  - s_req = 0 and m_resp = 0.
  - If any master valid is high, scan indices ptr, ptr+1, … mod N_MASTERS. The first master with valid=1 is loaded into sel, and state goes to BUSY.
  - If no master valid is high, the block stays IDLE.
- BUSY:
  - s_req = m_req slice[sel], passed through combinationally including valid.
  - m_resp slice[sel] = s_resp; all other m_resp slices are 0.
  - On s_resp.ready = 1: state goes to IDLE and ptr becomes (sel+1) mod N_MASTERS.
  - Without ready, the block stays BUSY regardless of the granted master's valid. A master that drops valid early simply forwards valid=0 (protocol violation, not recovered).
- Non-granted masters see ready=0 and keep valid asserted until they are served.
- s_resp.ready received while IDLE is ignored and not forwarded.
- Modulo wrap: ptr and sel wrap at N_MASTERS, not at 2^SEL_W. Indices ≥ N_MASTERS never appear.
- N_MASTERS=1: sel and ptr are always 0. The IDLE→BUSY cycle still applies.
- TYPE only changes REQ_W. Request fields are forwarded opaquely and never inspected beyond valid.

## Timing
- Reset state: state=IDLE, sel=0, ptr=0. Consequently s_req=0, m_resp=0 and s_sel=0.
- Reset in the middle of a transaction aborts it. Outputs are 0 in the cycle after rst is sampled low. A late slave ready is then ignored.
- Grant latency: a valid first sampled in IDLE at edge t gives s_req.valid=1 from edge t onward (after the state update), i.e. exactly 1 cycle of added request latency.
- Response latency: 0. The m_resp ready/rdata of the granted master equals s_resp in the same cycle.
- Ready at cycle k: state is IDLE at cycle k+1 and the next grant is registered at the end of k+1. Minimum spacing between back-to-back transactions is therefore 2 cycles of overhead.
- Native protocol: a master deasserts valid the cycle after ready. A valid still high in the IDLE cycle is treated as a new request.
- Simultaneous requests: only the arbitration order decides. No master is starved; worst-case wait is N_MASTERS-1 transactions.

## Test plan
- Reset: hold rst=0 for 2 cycles with all masters valid=1 -> s_req=0, m_resp=0, s_sel=0. After release, master 0 is granted first (ptr=0).
- Single master: N_MASTERS=2, master 1 write addr=0x100, wdata=0xDEADBEEF, wstrb=0xF; slave ready 3 cycles later -> s_sel=1. s_req equals master 1's request one cycle after valid. Master 1 gets a single ready pulse in the slave's ready cycle; master 0 sees m_resp=0 throughout.
- Round-robin: N_MASTERS=3 with all valid continuously, slave ready 1 cycle after each grant -> grant order 0,1,2,0,1. No index ≥3 appears.
- Read data: master 0 read with slave returning rdata=0x12345678, ready=1 -> m_resp slice 0 = {0x12345678, 1} that same cycle. The other slices are 0.
- Mid-transaction reset: grant master 1, assert rst=0 before ready, then the slave pulses ready after release -> outputs are 0 after reset. The stray ready is not forwarded and the next grant starts from master 0.
- Stray ready: slave ready=1 while IDLE with no requests -> m_resp stays 0 and state stays IDLE.

Source files
------------

// File: rtl/merge.sv
// Bus merge: round-robin arbitration of N_MASTERS native-bus masters onto one slave port.
// The grant is registered and held until the slave returns ready.

`ifndef D
`define D 1'b1
`endif
`ifndef I
`define I 1'b0
`endif
`ifndef BUS_REQ_W
`define BUS_REQ_W(t, aw) (((t) == `D) ? ((aw) + 37) : ((aw) + 1))
`endif
`ifndef BUS_RESP_W
`define BUS_RESP_W 33
`endif

module merge #(
  parameter logic        TYPE      = `D,
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  localparam int unsigned REQ_W    = `BUS_REQ_W(TYPE, ADDR_W),
  localparam int unsigned RESP_W   = `BUS_RESP_W,
  localparam int unsigned SEL_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS*REQ_W-1:0]  m_req,
  output logic [N_MASTERS*RESP_W-1:0] m_resp,
  output logic [REQ_W-1:0]            s_req,
  input  logic [RESP_W-1:0]           s_resp,
  output logic [SEL_W-1:0]            s_sel
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SEL_W-1:0]     r_sel;
  logic [SEL_W-1:0]     r_ptr;
  logic [SEL_W-1:0]     w_sel_nxt;
  logic [SEL_W-1:0]     w_ptr_nxt;
  logic [SEL_W-1:0]     w_pick;
  logic [SEL_W-1:0]     w_sel_inc;
  logic [N_MASTERS-1:0] w_valid;
  logic                 w_any;
  int unsigned          w_idx;

  always_comb begin
    w_valid = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      w_valid[i] = m_req[i*REQ_W + REQ_W - 1];
    end
  end

  // Scan from r_ptr upward; indices wrap at N_MASTERS, never at 2^SEL_W.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = 0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      w_idx = (32'(r_ptr) + k) % N_MASTERS;
      if (!w_any && w_valid[w_idx]) begin
        w_any  = 1'b1;
        w_pick = SEL_W'(w_idx);
      end
    end
  end

  assign w_sel_inc = SEL_W'((32'(r_sel) + 1) % N_MASTERS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = BUSY;
          w_sel_nxt   = w_pick;
        end
      end
      BUSY: begin
        if (s_resp[0]) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = w_sel_inc;
        end
      end
    endcase
  end

  // Only the granted slice is routed; a ready arriving while IDLE goes nowhere.
  always_comb begin
    s_req  = '0;
    m_resp = '0;
    s_sel  = '0;
    if (r_state == BUSY) begin
      s_sel = r_sel;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        if (r_sel == SEL_W'(i)) begin
          s_req                       = m_req[i*REQ_W +: REQ_W];
          m_resp[i*RESP_W +: RESP_W]  = s_resp;
        end
      end
    end
  end

endmodule

// File: tb/tb_merge.sv
// Directed bench for merge: a 2-master D-bus instance and a 3-master I-bus instance.
`ifndef D
`define D 1'b1
`endif
`ifndef I
`define I 1'b0
`endif

module tb_merge;

  localparam logic [68:0] R0 = {1'b1, 32'h0000_0040, 32'h1111_1111, 4'h1};
  localparam logic [68:0] R1 = {1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF};

  logic         clk;
  logic         rst;
  logic [137:0] m_req2;
  logic [65:0]  m_resp2;
  logic [68:0]  s_req2;
  logic [32:0]  s_resp2;
  logic [0:0]   s_sel2;
  logic [98:0]  m_req3;
  logic [98:0]  m_resp3;
  logic [32:0]  s_req3;
  logic [32:0]  s_resp3;
  logic [1:0]   s_sel3;

  logic [32:0]  r3 [3];
  logic [98:0]  e3;
  int           vectors;
  int           errs;

  merge #(.TYPE(`D), .N_MASTERS(2), .ADDR_W(32)) dut2 (
    .clk(clk), .rst(rst), .m_req(m_req2), .m_resp(m_resp2),
    .s_req(s_req2), .s_resp(s_resp2), .s_sel(s_sel2)
  );

  merge #(.TYPE(`I), .N_MASTERS(3), .ADDR_W(32)) dut3 (
    .clk(clk), .rst(rst), .m_req(m_req3), .m_resp(m_resp3),
    .s_req(s_req3), .s_resp(s_resp3), .s_sel(s_sel3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    r3[0] = {1'b1, 32'h0000_1000};
    r3[1] = {1'b1, 32'h0000_1001};
    r3[2] = {1'b1, 32'h0000_1002};

    // Reset held 2 cycles with every master requesting and a ready on the slave.
    rst     = 1'b0;
    m_req2  = {R1, R0};
    m_req3  = '0;
    s_resp2 = 33'h1;
    s_resp3 = '0;
    tick();
    tick();
    #1;
    chk("rst_sreq", 128'(s_req2), 128'h0);
    chk("rst_mresp", 128'(m_resp2), 128'h0);
    chk("rst_sel", 128'(s_sel2), 128'h0);
    chk("rst_sel3", 128'(s_sel3), 128'h0);

    rst     = 1'b1;
    s_resp2 = '0;
    #1;
    chk("lat_idle_sreq", 128'(s_req2), 128'h0);

    tick();
    #1;
    chk("first_grant_sel", 128'(s_sel2), 128'h0);
    chk("first_grant_sreq", 128'(s_req2), 128'(R0));
    chk("first_grant_mresp", 128'(m_resp2), 128'h0);

    s_resp2 = {32'h1234_5678, 1'b1};
    #1;
    chk("read_mresp", 128'(m_resp2), 128'({33'h0, 32'h1234_5678, 1'b1}));

    tick();
    m_req2  = {R1, 69'h0};
    s_resp2 = '0;
    #1;
    chk("gap_sreq", 128'(s_req2), 128'h0);
    chk("gap_sel", 128'(s_sel2), 128'h0);

    tick();
    #1;
    chk("m1_sel", 128'(s_sel2), 128'h1);
    chk("m1_sreq", 128'(s_req2), 128'(R1));
    chk("m1_wait_mresp", 128'(m_resp2), 128'h0);
    tick();
    #1;
    chk("m1_wait2_mresp", 128'(m_resp2), 128'h0);
    tick();
    s_resp2 = {32'hA5A5_A5A5, 1'b1};
    #1;
    chk("m1_ready_mresp", 128'(m_resp2), 128'({32'hA5A5_A5A5, 1'b1, 33'h0}));
    tick();
    m_req2  = '0;
    s_resp2 = '0;
    #1;
    chk("m1_done_sel", 128'(s_sel2), 128'h0);
    chk("m1_done_mresp", 128'(m_resp2), 128'h0);

    // Stray ready while idle with no requests.
    s_resp2 = {32'hCAFE_F00D, 1'b1};
    #1;
    chk("stray_mresp", 128'(m_resp2), 128'h0);
    tick();
    tick();
    #1;
    chk("stray_mresp2", 128'(m_resp2), 128'h0);
    chk("stray_sel", 128'(s_sel2), 128'h0);
    chk("stray_sreq", 128'(s_req2), 128'h0);
    s_resp2 = '0;

    // Mid-transaction reset.
    m_req2 = {R1, 69'h0};
    tick();
    #1;
    chk("mid_grant_sel", 128'(s_sel2), 128'h1);
    rst = 1'b0;
    tick();
    #1;
    chk("mid_rst_sel", 128'(s_sel2), 128'h0);
    chk("mid_rst_sreq", 128'(s_req2), 128'h0);
    chk("mid_rst_mresp", 128'(m_resp2), 128'h0);
    rst     = 1'b1;
    m_req2  = {R1, R0};
    s_resp2 = {32'h0BAD_BEEF, 1'b1};
    #1;
    chk("late_ready_mresp", 128'(m_resp2), 128'h0);
    tick();
    s_resp2 = '0;
    #1;
    chk("post_rst_sel", 128'(s_sel2), 128'h0);
    chk("post_rst_sreq", 128'(s_req2), 128'(R0));
    s_resp2 = 33'h1;
    tick();
    m_req2  = '0;
    s_resp2 = '0;
    #1;
    chk("post_rst_idle", 128'(s_sel2), 128'h0);

    // Round-robin on the 3-master instance with all masters requesting.
    m_req3 = {r3[2], r3[1], r3[0]};
    for (int g = 0; g < 5; g++) begin
      int unsigned ex;
      ex = g % 3;
      tick();
      #1;
      chk("rr_sel", 128'(s_sel3), 128'(ex));
      chk("rr_sreq", 128'(s_req3), 128'(r3[ex]));
      s_resp3 = {32'h0000_00B0 + 32'(ex), 1'b1};
      e3 = '0;
      e3[ex*33 +: 33] = s_resp3;
      #1;
      chk("rr_mresp", 128'(m_resp3), 128'(e3));
      tick();
      s_resp3 = '0;
      #1;
      chk("rr_idle_sel", 128'(s_sel3), 128'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
